// File: rtl/icache_sa_if.sv
// Fetcher/memory-controller bundle for the set-associative instruction cache.
// The master side is the environment (fetcher plus memory controller); the slave is the cache.
interface icache_sa_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
);
    logic                    rdy;
    logic                    flush;
    logic                    req_valid;
    logic [ADDR_W-1:0]       req_pc;
    logic                    resp_valid;
    logic [31:0]             resp_instr;
    logic                    mem_req;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_ack;
    logic [32*LINE_WORDS-1:0] mem_line;

    modport master (
        output rdy, flush, req_valid, req_pc, mem_ack, mem_line,
        input  resp_valid, resp_instr, mem_req, mem_addr
    );

    modport slave (
        input  rdy, flush, req_valid, req_pc, mem_ack, mem_line,
        output resp_valid, resp_instr, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_sa.sv
// Set-associative instruction cache with zero-cycle hits, round-robin replacement
// and a two-state miss/refill FSM that fetches one whole line per miss.
module icache_sa #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16,
    parameter int WAYS       = 2
) (
    input  logic        clk,
    input  logic        rst,
    icache_sa_if.slave  bus
);
    localparam int WOFF_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WOFF_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int VIC_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_W = 32 * LINE_WORDS;

    typedef enum logic {S_IDLE, S_MISS} state_t;

    state_t                    r_state, w_state_nxt;
    logic [SETS-1:0][WAYS-1:0] r_valid;
    logic [TAG_W-1:0]          r_tag    [SETS][WAYS];
    logic [LINE_W-1:0]         r_line   [SETS][WAYS];
    logic [VIC_W-1:0]          r_victim [SETS];
    logic [ADDR_W-1:0]         r_mem_addr;
    logic                      r_drop;

    logic [WOFF_W-1:0] w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [LINE_W-1:0] w_hit_line;
    int                w_hit_cnt;
    logic              w_hit;
    logic              w_miss_start;
    logic [IDX_W-1:0]  w_rf_idx;
    logic [TAG_W-1:0]  w_rf_tag;
    logic [VIC_W-1:0]  w_rf_way;
    logic              w_rf_free;
    logic              w_install;
    logic [1:0]        w_unused_pc;

    assign w_off       = bus.req_pc[OFF_W-1:2];
    assign w_idx       = bus.req_pc[OFF_W +: IDX_W];
    assign w_tag       = bus.req_pc[ADDR_W-1 -: TAG_W];
    assign w_unused_pc = bus.req_pc[1:0];

    assign w_rf_idx = r_mem_addr[OFF_W +: IDX_W];
    assign w_rf_tag = r_mem_addr[ADDR_W-1 -: TAG_W];

    // Tag compare across all ways of the addressed set
    always_comb begin
        w_hit_cnt  = 0;
        w_hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit_cnt  = w_hit_cnt + 1;
                w_hit_line = r_line[w_idx][w];
            end
        end
    end

    assign w_hit        = bus.req_valid && bus.rdy && (r_state == S_IDLE) && (w_hit_cnt == 1);
    assign w_miss_start = bus.req_valid && bus.rdy && (r_state == S_IDLE) && !w_hit && !bus.flush;

    assign bus.resp_valid = w_hit && !bus.flush;
    assign bus.resp_instr = w_hit_line[{w_off, 5'd0} +: 32];
    assign bus.mem_req    = (r_state == S_MISS);
    assign bus.mem_addr   = r_mem_addr;

    // Refill way choice: lowest invalid way first, otherwise the round-robin pointer
    always_comb begin
        w_rf_way  = r_victim[w_rf_idx];
        w_rf_free = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_rf_idx][w]) begin
                w_rf_way  = VIC_W'(w);
                w_rf_free = 1'b1;
            end
        end
    end

    // A flush seen at any point of the miss (or with the ack) discards the returning line
    assign w_install = (r_state == S_MISS) && bus.rdy && bus.mem_ack && !bus.flush && !r_drop;

    // Next-state logic: leave IDLE on a miss, leave MISS on an accepted ack
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_miss_start) w_state_nxt = S_MISS;
            S_MISS: if (bus.rdy && bus.mem_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Valid bits, victim pointers, refill address and the discard flag; all frozen while rdy=0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_mem_addr <= '0;
            r_drop     <= 1'b0;
            for (int s = 0; s < SETS; s++) r_victim[s] <= '0;
        end else if (bus.rdy) begin
            if (bus.flush)     r_valid <= '0;
            else if (w_install) r_valid[w_rf_idx][w_rf_way] <= 1'b1;
            if (w_install && !w_rf_free)
                r_victim[w_rf_idx] <= (r_victim[w_rf_idx] == VIC_W'(WAYS - 1)) ?
                                      '0 : r_victim[w_rf_idx] + 1'b1;
            if (w_miss_start) r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
            if (r_state == S_MISS) begin
                if (bus.mem_ack)    r_drop <= 1'b0;
                else if (bus.flush) r_drop <= 1'b1;
            end
        end
    end

    // Tag and line storage written only on an installing refill
    always_ff @(posedge clk) begin
        if (w_install) begin
            r_tag[w_rf_idx][w_rf_way]  <= w_rf_tag;
            r_line[w_rf_idx][w_rf_way] <= bus.mem_line;
        end
    end
endmodule

// File: tb/tb_icache_sa.sv
// Bench for icache_sa at default parameters: directed scenarios plus randomized
// fetch traffic compared against a set/way/round-robin reference model.
module tb_icache_sa;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    icache_sa_if #(.ADDR_W(32), .LINE_WORDS(4)) bus ();

    icache_sa #(.ADDR_W(32), .LINE_WORDS(4), .SETS(16), .WAYS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: what each set holds, by line tag, and where replacement points
    bit           m_val  [16][2];
    logic [23:0]  m_tag  [16][2];
    logic [127:0] m_data [16][2];
    int           m_ptr  [16];

    function automatic void model_reset();
        for (int s = 0; s < 16; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < 2; w++) m_val[s][w] = 0;
        end
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 2; w++) m_val[s][w] = 0;
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output logic hit, output logic [31:0] instr);
        int s;
        s = int'(pc[7:4]);
        hit = 1'b0;
        instr = 32'h0;
        for (int w = 0; w < 2; w++)
            if (m_val[s][w] && m_tag[s][w] == pc[31:8]) begin
                hit = 1'b1;
                instr = m_data[s][w][int'(pc[3:2]) * 32 +: 32];
            end
    endfunction

    function automatic void model_install(input logic [31:0] addr, input logic [127:0] line);
        int s, way;
        s = int'(addr[7:4]);
        if (!m_val[s][0])      way = 0;
        else if (!m_val[s][1]) way = 1;
        else begin
            way = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % 2;
        end
        m_val[s][way]  = 1;
        m_tag[s][way]  = addr[31:8];
        m_data[s][way] = line;
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.flush = 1'b0;
        bus.mem_ack = 1'b0;
        bus.rdy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // One lookup; on a miss it serves the refill after lat cycles and checks the follow-up hit
    task automatic fetch(input logic [31:0] pc, input int lat, input logic [127:0] line, output logic got_hit);
        logic        exp_hit;
        logic [31:0] exp_instr;
        model_lookup(pc, exp_hit, exp_instr);
        bus.req_valid = 1'b1;
        bus.req_pc = pc;
        @(negedge clk);
        got_hit = bus.resp_valid;
        n_vec++;
        if (bus.resp_valid !== exp_hit) begin
            n_err++;
            $display("FAIL lookup_hit pc=%h got %b want %b", pc, bus.resp_valid, exp_hit);
        end
        if (exp_hit) begin
            n_vec++;
            if (bus.resp_instr !== exp_instr) begin
                n_err++;
                $display("FAIL hit_instr pc=%h got %h want %h", pc, bus.resp_instr, exp_instr);
            end
            tick();
            bus.req_valid = 1'b0;
            return;
        end
        tick();
        n_vec++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== {pc[31:4], 4'h0}) begin
            n_err++;
            $display("FAIL miss_req pc=%h got req=%b addr=%h want req=1 addr=%h",
                     pc, bus.mem_req, bus.mem_addr, {pc[31:4], 4'h0});
        end
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.mem_req !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mem_addr !== {pc[31:4], 4'h0}) begin
                n_err++;
                $display("FAIL miss_wait pc=%h got req=%b resp=%b addr=%h want req=1 resp=0",
                         pc, bus.mem_req, bus.resp_valid, bus.mem_addr);
            end
            tick();
        end
        bus.mem_ack = 1'b1;
        bus.mem_line = line;
        tick();
        bus.mem_ack = 1'b0;
        model_install({pc[31:4], 4'h0}, line);
        model_lookup(pc, exp_hit, exp_instr);
        @(negedge clk);
        n_vec++;
        if (bus.mem_req !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_instr !== exp_instr) begin
            n_err++;
            $display("FAIL refill_hit pc=%h got req=%b resp=%b instr=%h want req=0 resp=1 instr=%h",
                     pc, bus.mem_req, bus.resp_valid, bus.resp_instr, exp_instr);
        end
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_pc = 32'h0;
        bus.flush = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_line = '0;
        bus.rdy = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_vec++;
        if (bus.resp_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs got resp=%b req=%b addr=%h want 0 0 0",
                     bus.resp_valid, bus.mem_req, bus.mem_addr);
        end
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic_miss();
        logic h;
        do_reset();
        fetch(32'h0000_1004, 2, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, h);
        n_vec++;
        if (h !== 1'b0) begin n_err++; $display("FAIL basic_first_miss got %b want 0", h); end
        bus.req_valid = 1'b1;
        bus.req_pc = 32'h0000_100C;
        @(negedge clk);
        n_vec++;
        if (bus.resp_valid !== 1'b1 || bus.resp_instr !== 32'hA3) begin
            n_err++;
            $display("FAIL basic_word3 got resp=%b instr=%h want 1 000000a3", bus.resp_valid, bus.resp_instr);
        end
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_rr_evict();
        logic h;
        do_reset();
        fetch(32'h1000, 0, rand_line(), h);
        fetch(32'h2000, 1, rand_line(), h);
        fetch(32'h3000, 0, rand_line(), h);
        fetch(32'h2000, 0, rand_line(), h);
        n_vec++;
        if (h !== 1'b1) begin n_err++; $display("FAIL rr_2000_kept got %b want 1", h); end
        fetch(32'h1000, 0, rand_line(), h);
        n_vec++;
        if (h !== 1'b0) begin n_err++; $display("FAIL rr_1000_evicted got %b want 0", h); end
        fetch(32'h3000, 0, rand_line(), h);
        n_vec++;
        if (h !== 1'b1) begin n_err++; $display("FAIL rr_3000_kept got %b want 1", h); end
        fetch(32'h2000, 0, rand_line(), h);
        n_vec++;
        if (h !== 1'b0) begin n_err++; $display("FAIL rr_2000_replaced got %b want 0", h); end
    endtask

    task automatic test_flush_idle();
        logic h;
        do_reset();
        fetch(32'h1000, 1, rand_line(), h);
        bus.req_valid = 1'b1;
        bus.req_pc = 32'h1000;
        bus.flush = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_forces_no_resp got %b want 0", bus.resp_valid);
        end
        tick();
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        model_flush();
        n_vec++;
        if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL flush_no_miss got req=%b want 0", bus.mem_req); end
        fetch(32'h1000, 1, rand_line(), h);
        n_vec++;
        if (h !== 1'b0) begin n_err++; $display("FAIL flush_remiss got %b want 0", h); end
    endtask

    task automatic test_flush_miss();
        logic h;
        do_reset();
        bus.req_valid = 1'b1;
        bus.req_pc = 32'h4000;
        tick();
        bus.req_valid = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        model_flush();
        tick();
        n_vec++;
        if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL flushmiss_still_waiting got %b want 1", bus.mem_req); end
        bus.mem_ack = 1'b1;
        bus.mem_line = rand_line();
        tick();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL flushmiss_back_idle got %b want 0", bus.mem_req); end
        tick();
        fetch(32'h4000, 1, rand_line(), h);
        n_vec++;
        if (h !== 1'b0) begin n_err++; $display("FAIL flushmiss_not_installed got %b want 0", h); end
        // Flush coinciding with the ack also discards the line
        bus.req_valid = 1'b1;
        bus.req_pc = 32'h4100;
        tick();
        bus.req_valid = 1'b0;
        bus.flush = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.mem_ack = 1'b0;
        model_flush();
        fetch(32'h4100, 0, rand_line(), h);
        n_vec++;
        if (h !== 1'b0) begin n_err++; $display("FAIL flush_with_ack_not_installed got %b want 0", h); end
    endtask

    task automatic test_rdy_freeze();
        logic         exp_hit;
        logic [31:0]  exp_instr;
        logic [127:0] line;
        do_reset();
        line = rand_line();
        bus.req_valid = 1'b1;
        bus.req_pc = 32'h7008;
        tick();
        bus.rdy = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_line = rand_line();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.mem_req !== 1'b1 || bus.resp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rdy0_hold cyc=%0d got req=%b resp=%b want 1 0", i, bus.mem_req, bus.resp_valid);
            end
            tick();
        end
        bus.rdy = 1'b1;
        bus.mem_line = line;
        tick();
        bus.mem_ack = 1'b0;
        model_install(32'h7000, line);
        model_lookup(32'h7008, exp_hit, exp_instr);
        @(negedge clk);
        n_vec++;
        if (bus.resp_valid !== 1'b1 || bus.resp_instr !== line[95:64] || exp_instr !== line[95:64]) begin
            n_err++;
            $display("FAIL rdy_reack_install got resp=%b instr=%h want 1 %h", bus.resp_valid, bus.resp_instr, line[95:64]);
        end
        tick();
        // rdy=0 also suppresses a hit response
        bus.rdy = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL rdy0_no_resp got %b want 0", bus.resp_valid); end
        tick();
        bus.rdy = 1'b1;
        bus.req_valid = 1'b0;
    endtask

    task automatic test_redirect();
        logic         h;
        logic [127:0] line5;
        logic [127:0] line6;
        do_reset();
        line5 = rand_line();
        line6 = rand_line();
        bus.req_valid = 1'b1;
        bus.req_pc = 32'h5000;
        tick();
        bus.req_pc = 32'h6000;
        tick();
        bus.mem_ack = 1'b1;
        bus.mem_line = line5;
        @(negedge clk);
        n_vec++;
        if (bus.resp_valid !== 1'b0 || bus.mem_addr !== 32'h5000) begin
            n_err++;
            $display("FAIL redirect_held got resp=%b addr=%h want 0 00005000", bus.resp_valid, bus.mem_addr);
        end
        tick();
        bus.mem_ack = 1'b0;
        model_install(32'h5000, line5);
        @(negedge clk);
        n_vec++;
        if (bus.resp_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL redirect_no_resp got resp=%b req=%b want 0 0", bus.resp_valid, bus.mem_req);
        end
        tick();
        n_vec++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h6000) begin
            n_err++;
            $display("FAIL redirect_new_miss got req=%b addr=%h want 1 00006000", bus.mem_req, bus.mem_addr);
        end
        bus.mem_ack = 1'b1;
        bus.mem_line = line6;
        tick();
        bus.mem_ack = 1'b0;
        model_install(32'h6000, line6);
        bus.req_valid = 1'b0;
        fetch(32'h5004, 0, rand_line(), h);
        n_vec++;
        if (h !== 1'b1) begin n_err++; $display("FAIL redirect_5000_installed got %b want 1", h); end
        fetch(32'h600C, 0, rand_line(), h);
        n_vec++;
        if (h !== 1'b1) begin n_err++; $display("FAIL redirect_6000_installed got %b want 1", h); end
    endtask

    task automatic test_reset_mid_miss();
        logic h;
        do_reset();
        bus.req_valid = 1'b1;
        bus.req_pc = 32'h8000;
        tick();
        bus.req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_vec++;
        if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mid_miss got req=%b want 0", bus.mem_req); end
        tick();
        bus.mem_ack = 1'b1;
        bus.mem_line = rand_line();
        tick();
        bus.mem_ack = 1'b0;
        fetch(32'h8000, 0, rand_line(), h);
        n_vec++;
        if (h !== 1'b0) begin n_err++; $display("FAIL late_ack_ignored got %b want 0", h); end
    endtask

    task automatic test_random();
        logic        h;
        logic [31:0] pc;
        do_reset();
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(15) == 0) begin
                bus.flush = 1'b1;
                bus.req_valid = 1'b1;
                bus.req_pc = 32'h0;
                @(negedge clk);
                n_vec++;
                if (bus.resp_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
                    n_err++;
                    $display("FAIL rand_flush got resp=%b req=%b want 0 0", bus.resp_valid, bus.mem_req);
                end
                tick();
                bus.flush = 1'b0;
                bus.req_valid = 1'b0;
                model_flush();
            end
            pc = {21'h0, 3'($urandom_range(5)), 2'b00, 2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3))};
            fetch(pc, int'($urandom_range(3)), rand_line(), h);
        end
    endtask

    initial begin
        test_reset();
        test_basic_miss();
        test_rr_evict();
        test_flush_idle();
        test_flush_miss();
        test_rdy_freeze();
        test_redirect();
        test_reset_mid_miss();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached with %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
Parametrised set-associative instruction cache between the instruction fetcher and the memory controller. It supersedes the single-way cache with configurable sets, ways and line width, plus round-robin replacement. It also adds an explicit miss/refill state machine with a mem_req/mem_ack handshake, and a flush input for fence.i and pipeline reset. Hits return the instruction in the same cycle; misses fetch one whole line from the memory controller.

Parameters:
ADDR_W, 32, address and instruction-PC width
LINE_WORDS, 4, 32-bit instructions per line (power of 2, ≥2)
SETS, 16, number of sets (power of 2, ≥2)
WAYS, 2, associativity (power of 2, 1..8)
Derived: OFF_W = log2(LINE_WORDS)+2, IDX_W = log2(SETS), TAG_W = ADDR_W-IDX_W-OFF_W

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global ready; low = freeze all state
flush  in  1  invalidate all lines
req_valid  in  1  fetcher lookup request
req_pc  in  ADDR_W  fetch address; bits [1:0] ignored
resp_valid  out  1  instruction valid this cycle
resp_instr  out  32  instruction at req_pc
mem_req  out  1  line refill request to memory controller
mem_addr  out  ADDR_W  line-aligned refill address (low OFF_W bits zero)
mem_ack  in  1  one-cycle pulse; mem_line valid this cycle
mem_line  in  32*LINE_WORDS  refill data; word k at bits [32k+31:32k]

Behaviour:
- Address split: offset = req_pc[OFF_W-1:2], index = req_pc[OFF_W+IDX_W-1:OFF_W], tag = req_pc[ADDR_W-1:OFF_W+IDX_W].
- Storage per set and way: valid bit, tag, line. Per set: round-robin victim pointer, log2(WAYS) bits, wraps from WAYS-1 to 0.
- Reset: all valid bits 0, all victim pointers 0, state IDLE. Outputs: resp_valid=0, mem_req=0, mem_addr=0. resp_instr is don't-care when resp_valid=0.
- hit = req_valid & rdy & state==IDLE & (exactly one way with valid and matching tag). Two matching ways in one set is illegal and must never be created.
- On hit: resp_valid=1 and resp_instr = hitting line word[offset], combinationally, in the same cycle. Zero-cycle latency.
- FSM states:
  IDLE: if req_valid & ~hit & ~flush, latch line address {tag,index,0} into mem_addr and go to MISS. resp_valid=0.
  MISS: mem_req=1. mem_addr is held stable. Wait for mem_ack. On mem_ack, write mem_line, tag and valid=1 into way victim[index], advance victim[index], go to IDLE, drop mem_req the next cycle.
- Refill hit-under-miss is not supported. The first lookup of the refilled address hits in the cycle after mem_ack, giving miss latency = 1 + memory latency + 1 cycles.
- The fetcher may change req_pc during MISS, e.g. on a branch redirect. The refill still completes for the latched address, then a new lookup starts. No response is issued for the abandoned PC.
- Victim choice: if the set has an invalid way, the lowest-numbered invalid way is used and the pointer is not advanced. Otherwise the way at the pointer is used.
- flush in IDLE: all valid bits are cleared at the clock edge, and resp_valid is forced to 0 in that cycle.
- flush in MISS: all valid bits are cleared. The outstanding refill still waits for mem_ack, but the returned line is discarded (not installed). The FSM then returns to IDLE.
- flush together with mem_ack: flush wins and the line is not installed.
- rdy=0: no state, storage or pointer changes. resp_valid=0. mem_req keeps its value. A mem_ack seen while rdy=0 is ignored, and the memory controller must re-present it.
- rst mid-miss: the FSM returns to IDLE and mem_req drops in the next cycle. Any later mem_ack is ignored in IDLE.
- req_valid=0: no lookup, no miss, resp_valid=0.

Test Plan:
(Default parameters: index = pc[7:4], tag = pc[31:8].)
1. Reset, then req_pc=0x0000_1004 → resp_valid=0; next cycle mem_req=1, mem_addr=0x0000_1000. On mem_ack with words {0xA0,0xA1,0xA2,0xA3}, the following cycle gives resp_valid=1, resp_instr=0xA1. req_pc=0x0000_100C then gives 0xA3 with zero-cycle latency.
2. Fill 0x1000, 0x2000 and 0x3000 (same set 0) → the third fill evicts way 0 (0x1000). 0x2000 still hits; 0x1000 misses again and replaces 0x2000.
3. Fill 0x1000, pulse flush, request 0x1000 → resp_valid=0 and mem_req=1, i.e. it re-misses.
4. Miss on 0x4000, flush asserted during MISS, mem_ack arrives → line not installed, FSM back in IDLE, and 0x4000 misses again.
5. During MISS, hold rdy=0 for 3 cycles while mem_ack pulses → ack ignored and mem_req stays 1. Re-issue mem_ack with rdy=1 → line installed.
6. During MISS for 0x5000, change req_pc to 0x6000 → refill installs 0x5000, then a miss for mem_addr=0x6000 starts, and no resp_valid is issued for 0x5000.
